// File: rtl/ex_stage.sv
// RV32I execute stage: single-cycle ALU, branch and jump resolution, plus a
// serial shifter that raises hold_flag_o to stall the front end while it runs.
module ex_stage #(
    parameter int SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        reg_wen_i,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        reg_wen_o,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        hold_flag_o
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [4:0] STEP       = 5'(SHIFT_STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        fill_q, fill_d;
    logic        left_q, left_d;

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [31:0]        b_imm;
    logic [31:0]        j_imm;
    logic [4:0]         shamt;
    logic               is_shift;
    logic               wen_ok;
    logic signed [31:0] op1_s;
    logic signed [31:0] op2_s;
    logic [31:0]        alu_res;
    logic               br_taken;
    logic [4:0]         step_amt;

    // Shift by amt; right shifts fill vacated bits with the latched fill bit.
    function automatic logic [31:0] shift_by(input logic [31:0] v, input logic [4:0] amt,
                                             input logic left, input logic fill);
        logic [31:0] mask;
        mask = ~(32'hFFFF_FFFF >> amt);
        if (left)
            return v << amt;
        else
            return (v >> amt) | (fill ? mask : 32'h0);
    endfunction

    assign opcode   = inst_i[6:0];
    assign funct3   = inst_i[14:12];
    assign b_imm    = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign j_imm    = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign shamt    = op2_i[4:0];
    assign is_shift = ((opcode == OPC_OP) || (opcode == OPC_OP_IMM)) &&
                      ((funct3 == 3'b001) || (funct3 == 3'b101));
    assign wen_ok   = reg_wen_i && (rd_addr_i != 5'd0);
    assign op1_s    = op1_i;
    assign op2_s    = op2_i;
    assign step_amt = (cnt_q < STEP) ? cnt_q : STEP;

    always_comb begin
        alu_res = 32'h0;
        case (funct3)
            3'b000:  alu_res = ((opcode == OPC_OP) && inst_i[30]) ? (op1_i - op2_i)
                                                                  : (op1_i + op2_i);
            3'b010:  alu_res = {31'h0, (op1_s < op2_s)};
            3'b011:  alu_res = {31'h0, (op1_i < op2_i)};
            3'b100:  alu_res = op1_i ^ op2_i;
            3'b110:  alu_res = op1_i | op2_i;
            3'b111:  alu_res = op1_i & op2_i;
            default: alu_res = 32'h0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (op1_i == op2_i);
            3'b001:  br_taken = (op1_i != op2_i);
            3'b100:  br_taken = (op1_s < op2_s);
            3'b101:  br_taken = (op1_s >= op2_s);
            3'b110:  br_taken = (op1_i < op2_i);
            3'b111:  br_taken = (op1_i >= op2_i);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        fill_d      = fill_q;
        left_d      = left_q;
        rd_addr_o   = rd_addr_i;
        rd_data_o   = 32'h0;
        reg_wen_o   = 1'b0;
        jump_en_o   = 1'b0;
        jump_addr_o = 32'h0;
        hold_flag_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                case (opcode)
                    OPC_OP, OPC_OP_IMM: begin
                        if (is_shift && (shamt != 5'd0)) begin
                            // op1_i is captured only here; the fill bit is frozen for SRA.
                            acc_d       = op1_i;
                            cnt_d       = shamt;
                            left_d      = (funct3 == 3'b001);
                            fill_d      = (funct3 == 3'b101) && inst_i[30] && op1_i[31];
                            hold_flag_o = 1'b1;
                            state_d     = S_SHIFT;
                        end else begin
                            rd_data_o = is_shift ? op1_i : alu_res;
                            reg_wen_o = wen_ok;
                        end
                    end
                    OPC_BRANCH: begin
                        jump_en_o   = br_taken;
                        jump_addr_o = br_taken ? (inst_addr_i + b_imm) : 32'h0;
                    end
                    OPC_JAL: begin
                        jump_en_o   = 1'b1;
                        jump_addr_o = inst_addr_i + j_imm;
                        rd_data_o   = inst_addr_i + 32'd4;
                        reg_wen_o   = wen_ok;
                    end
                    OPC_JALR: begin
                        jump_en_o   = 1'b1;
                        jump_addr_o = (op1_i + op2_i) & ~32'h1;
                        rd_data_o   = inst_addr_i + 32'd4;
                        reg_wen_o   = wen_ok;
                    end
                    OPC_LUI: begin
                        rd_data_o = op2_i;
                        reg_wen_o = wen_ok;
                    end
                    OPC_AUIPC: begin
                        rd_data_o = inst_addr_i + op2_i;
                        reg_wen_o = wen_ok;
                    end
                    default: ;
                endcase
            end
            S_SHIFT: begin
                hold_flag_o = 1'b1;
                acc_d       = shift_by(acc_q, step_amt, left_q, fill_q);
                cnt_d       = cnt_q - step_amt;
                if (cnt_d == 5'd0)
                    state_d = S_DONE;
            end
            S_DONE: begin
                rd_data_o = acc_q;
                reg_wen_o = wen_ok;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are forced quiet for the whole time reset is held.
        if (rst) begin
            rd_addr_o   = 5'd0;
            rd_data_o   = 32'h0;
            reg_wen_o   = 1'b0;
            jump_en_o   = 1'b0;
            jump_addr_o = 32'h0;
            hold_flag_o = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= 32'h0;
            cnt_q   <= 5'd0;
            fill_q  <= 1'b0;
            left_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            left_q  <= left_d;
        end
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter SHIFT_STEP, default 1: bits shifted per SHIFT cycle; legal values 1, 2, 4, 8.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 inst_i  input  32  instruction from the ID/EX register; NOP is 32'h00000013.
REQ-005 inst_addr_i  input  32  PC of inst_i.
REQ-006 op1_i  input  32  rs1 value, or the PC for AUIPC.
REQ-007 op2_i  input  32  rs2 value (R-type, branch) or the sign-extended immediate (I/U/JALR).
REQ-008 rd_addr_i  input  5  destination register.
REQ-009 reg_wen_i  input  1  write-enable from decode.
REQ-010 rd_addr_o  output  5  writeback register address.
REQ-011 rd_data_o  output  32  writeback data.
REQ-012 reg_wen_o  output  1  writeback enable.
REQ-013 jump_en_o  output  1  redirect request to fetch; also the flush for the IF/ID and ID/EX registers.
REQ-014 jump_addr_o  output  32  redirect target.
REQ-015 hold_flag_o  output  1  stall request; while high, PC, IF/ID and ID/EX hold their values.

Function
REQ-016 Supported operations: OP, OP-IMM, BRANCH, JAL, JALR, LUI and AUIPC. Any other opcode SHALL yield reg_wen_o=0, jump_en_o=0 and hold_flag_o=0.
REQ-017 All non-shift operations SHALL complete combinationally in one cycle with hold_flag_o=0.
REQ-018 ADD/SUB/SLT/SLTU/XOR/OR/AND and their immediate forms SHALL follow RV32I semantics, mod 2^32.
REQ-019 LUI: rd_data_o=op2_i.
REQ-020 AUIPC: rd_data_o=inst_addr_i+op2_i.
REQ-021 JAL: jump_addr_o=inst_addr_i+J-imm, where J-imm is decoded from inst_i.
REQ-022 JALR: jump_addr_o=(op1_i+op2_i)&~1.
REQ-023 JAL and JALR: rd_data_o=inst_addr_i+4 and jump_en_o=1.
REQ-024 BEQ/BNE/BLT/BGE/BLTU/BGEU: compare op1_i with op2_i.
REQ-025 A taken branch SHALL drive jump_en_o=1 and jump_addr_o=inst_addr_i+B-imm.
REQ-026 A not-taken branch SHALL drive jump_en_o=0.
REQ-027 Branches SHALL drive reg_wen_o=0.
REQ-028 reg_wen_o SHALL be forced to 0 whenever rd_addr_i==0.
REQ-029 When jump_en_o=0, jump_addr_o SHALL be 0.
REQ-030 SLL/SRL/SRA/SLLI/SRLI/SRAI use a serial shifter with an FSM of three states: IDLE, SHIFT, DONE.
REQ-031 Shift amount: shamt=op2_i[4:0].
REQ-032 In IDLE with a shift and shamt==0: single-cycle result rd_data_o=op1_i, hold_flag_o=0, FSM stays in IDLE.
REQ-033 In IDLE with a shift and shamt>0: load acc<=op1_i and cnt<=shamt, drive hold_flag_o=1 and reg_wen_o=0, then go to SHIFT.
REQ-034 In SHIFT: each cycle shift acc by min(SHIFT_STEP, cnt) and subtract the same amount from cnt.
REQ-035 Shift fill: SRA fills with the original op1_i[31]; SRL and SLL fill with 0.
REQ-036 In SHIFT, hold_flag_o=1 and reg_wen_o=0; the FSM goes to DONE when cnt would reach 0.
REQ-037 In DONE: rd_data_o=acc, reg_wen_o follows REQ-028, hold_flag_o=0, and the FSM returns to IDLE next cycle.
REQ-038 hold_flag_o SHALL be high for exactly 1+ceil(shamt/SHIFT_STEP) consecutive cycles.
REQ-039 For shamt=31 and SHIFT_STEP=1, that is 32 cycles.
REQ-040 Inputs are stable during a hold; the shifter SHALL sample op1_i only in IDLE.
REQ-041 A shift never asserts jump_en_o.
REQ-042 A shift that immediately follows another shift SHALL start cleanly from IDLE, with no idle bubble beyond DONE.

Reset
REQ-043 While rst=1, every output SHALL be 0, the FSM SHALL be IDLE, and acc and cnt SHALL be 0.
REQ-044 Asserting rst in the middle of a shift SHALL abort the shift immediately; no write occurs.
REQ-045 The first edge after rst deasserts SHALL evaluate inst_i from IDLE.

Verification
REQ-046 ADDI, rd=5, op1=7, op2=-3 -> same cycle: rd_data_o=4, reg_wen_o=1, hold_flag_o=0.
REQ-047 BEQ at PC 0x100, op1=op2=9, B-imm=-8 -> jump_en_o=1, jump_addr_o=0xF8, reg_wen_o=0.
REQ-048 BNE with op1=op2 -> jump_en_o=0, jump_addr_o=0.
REQ-049 SRAI, op1=0x80000000, shamt=4, SHIFT_STEP=1 -> hold_flag_o high for 5 cycles; in DONE, rd_data_o=0xF8000000 and reg_wen_o=1 for one cycle.
REQ-050 SLL with shamt=0, op1=0x1234 -> rd_data_o=0x1234 in one cycle, no hold.
REQ-051 SLLI, rd=0, shamt=31, SHIFT_STEP=4 -> hold_flag_o high for 9 cycles; reg_wen_o=0 throughout.
REQ-052 rst pulse during the third SHIFT cycle -> all outputs 0 at once; a fresh ADD executes correctly after release.
REQ-053 JALR at PC 0x200, op1=0x1001, op2=4 -> jump_addr_o=0x1004, rd_data_o=0x204.
